// File: rtl/hash_loader_pkg.sv
// hash_loader_pkg: shared state encoding and byte-order helper for the hash RAM loader
package hash_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, READY} state_t;
  localparam int WORD_BYTES = 8;
  function automatic logic [63:0] byte_rev(input logic [63:0] d);
    for (int i = 0; i < WORD_BYTES; i++) byte_rev[8*i +: 8] = d[8*(WORD_BYTES-1-i) +: 8];
  endfunction
endpackage

// File: rtl/loader_addr_gen.sv
// loader_addr_gen: write address and remaining-word tracking for one load
module loader_addr_gen #(
  parameter int ADDR_W = 32,
  parameter int CNT_W = 16,
  parameter int ADDR_STRIDE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [CNT_W-1:0] remain_q;
  assign last = remain_q == CNT_W'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      remain_q <= '0;
    end else if (load) begin
      addr <= base;
      remain_q <= count;
    end else if (step) begin
      addr <= addr + ADDR_W'(ADDR_STRIDE);
      remain_q <= remain_q - 1'b1;
    end
  end
endmodule

// File: rtl/hash_ram_loader.sv
// hash_ram_loader: streams 64-bit hash words into the HASH RAM and flags hash_ready when committed
module hash_ram_loader
  import hash_loader_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W = 16,
  parameter int ADDR_STRIDE = 8,
  parameter int BYTE_SWAP = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              s_valid,
  input  logic [63:0]       s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [63:0]       ram_wdata,
  output logic [7:0]        ram_wmask,
  output logic              ram_wen,
  output logic              hash_ready,
  input  logic              release_buf,
  output logic              busy,
  output logic [CNT_W-1:0]  words_done
);
  state_t state;
  logic hs, last, accept;
  logic [ADDR_W-1:0] addr_q;
  assign s_ready = state == LOAD;
  assign hs = s_valid & s_ready;
  assign accept = start & (state == IDLE);
  loader_addr_gen #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .ADDR_STRIDE(ADDR_STRIDE)) u_addr (
    .clk(clk), .rst(rst), .load(accept), .step(hs),
    .base(base_addr), .count(word_count), .addr(addr_q), .last(last)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ram_wen <= 1'b0;
      ram_wmask <= '0;
      ram_waddr <= '0;
      ram_wdata <= '0;
      hash_ready <= 1'b0;
      busy <= 1'b0;
      words_done <= '0;
    end else begin
      ram_wen <= hs;
      ram_wmask <= {WORD_BYTES{hs}};
      if (hs) begin
        ram_waddr <= addr_q;
        ram_wdata <= BYTE_SWAP != 0 ? byte_rev(s_data) : s_data;
        words_done <= words_done + 1'b1;
      end
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          words_done <= '0;
          hash_ready <= word_count == '0;
          state <= word_count == '0 ? READY : LOAD;
        end
        LOAD: if (hs && last) state <= FLUSH;
        FLUSH: begin
          hash_ready <= 1'b1;
          state <= READY;
        end
        READY: if (release_buf) begin
          hash_ready <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
